// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared types and helpers for the SPI burst RAM slave.
package spi_ram_pkg;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    SHIFT_IN,
    READ_WAIT,
    SHIFT_OUT,
    DONE
  } state_e;

  // Payload width: wide enough to carry either an address or a data word.
  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// spi_ram_mem: single-port RAM with registered read. Contents are not reset.
module spi_ram_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_SIZE-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  // Write and registered read share the one address port.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= din;
    if (re) dout <= mem_q[addr];
  end

endmodule

// File: rtl/spi_burst_ram.sv
// spi_burst_ram: SPI slave owning a single-port RAM, with auto-incrementing
// write/read pointers. Frame = 2-bit command + W payload bits, MSB first.
// Optional feature macro: SPI_BURST_EN (stream WR_DATA / RD_DATA words while
// SS_n stays low). Without it every frame carries exactly one word.
module spi_burst_ram
  import spi_ram_pkg::*;
#(
  parameter int ADDR_SIZE  = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  localparam int W   = max_w(ADDR_SIZE, DATA_WIDTH);
  localparam int ICW = $clog2(W + 1);
  localparam int OCW = $clog2(DATA_WIDTH + 1);
  localparam logic [ICW-1:0]       IC_LAST  = ICW'(W - 1);
  localparam logic [OCW-1:0]       OC_LAST  = OCW'(DATA_WIDTH);
  localparam logic [OCW-1:0]       OC_ONE   = OCW'(1);
  localparam logic [ADDR_SIZE:0]   DEPTH_X  = (ADDR_SIZE + 1)'(MEM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] PTR_LAST = ADDR_SIZE'(MEM_DEPTH - 1);
`ifdef SPI_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  // Pointer advance with wrap at the (possibly non-power-of-two) depth.
  function automatic logic [ADDR_SIZE-1:0] ptr_inc(input logic [ADDR_SIZE-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  state_e                 state_q, state_d;
  logic [1:0]             cmd_q, cmd_d;
  logic [W-1:0]           ish_q, ish_d;
  logic [ICW-1:0]         icnt_q, icnt_d;
  logic [DATA_WIDTH-1:0]  osh_q, osh_d;
  logic [OCW-1:0]         ocnt_q, ocnt_d;
  logic [ADDR_SIZE-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0]   rd_ptr_q, rd_ptr_d;
  logic                   miso_q, miso_d;

  logic [W-1:0]           payload;
  logic [ADDR_SIZE-1:0]   addr_in;
  logic                   addr_ok;
  logic                   load;
  logic                   mem_we, mem_re;
  logic [ADDR_SIZE-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]  mem_dout;

  // The word completing at this edge includes the bit on MOSI right now.
  assign payload  = W'({ish_q, MOSI});
  assign addr_in  = payload[ADDR_SIZE-1:0];
  assign addr_ok  = ({1'b0, addr_in} < DEPTH_X);
  assign mem_addr = mem_we ? wr_ptr_q : rd_ptr_q;
  // Output shifter (re)load: after the read wait, or back-to-back in a burst.
  assign load = !SS_n && ((state_q == READ_WAIT) ||
                (BURST && state_q == SHIFT_OUT && ocnt_q == OC_LAST));
  assign MISO = miso_q;

  spi_ram_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_SIZE (ADDR_SIZE),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk (clk),
    .we  (mem_we),
    .re  (mem_re),
    .addr(mem_addr),
    .din (payload[DATA_WIDTH-1:0]),
    .dout(mem_dout)
  );

  // State register; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: SS_n high always returns to IDLE, discarding partial words.
  always_comb begin
    state_d = state_q;
    if (SS_n) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:      state_d = CMD;
        CMD:       state_d = SHIFT_IN;
        SHIFT_IN:
          if (icnt_q == IC_LAST) begin
            if (cmd_q == CMD_RD_DATA)                state_d = READ_WAIT;
            else if (BURST && cmd_q == CMD_WR_DATA)  state_d = SHIFT_IN;
            else                                     state_d = DONE;
          end
        READ_WAIT: state_d = SHIFT_OUT;
        SHIFT_OUT: if (ocnt_q == OC_LAST) state_d = BURST ? SHIFT_OUT : DONE;
        DONE:      state_d = DONE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Datapath/outputs: shifters, pointers, RAM strobes and next MISO bit.
  always_comb begin
    cmd_d    = cmd_q;
    ish_d    = ish_q;
    icnt_d   = icnt_q;
    osh_d    = osh_q;
    ocnt_d   = ocnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    miso_d   = 1'b0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    if (!SS_n) begin
      unique case (state_q)
        IDLE: cmd_d[1] = MOSI;
        CMD: begin
          cmd_d[0] = MOSI;
          icnt_d   = '0;
        end
        SHIFT_IN: begin
          ish_d  = payload;
          icnt_d = icnt_q + 1'b1;
          if (icnt_q == IC_LAST) begin
            icnt_d = '0;
            unique case (cmd_e'(cmd_q))
              CMD_WR_ADDR: if (addr_ok) wr_ptr_d = addr_in;
              CMD_WR_DATA: begin
                mem_we   = 1'b1;
                wr_ptr_d = ptr_inc(wr_ptr_q);
              end
              CMD_RD_ADDR: if (addr_ok) rd_ptr_d = addr_in;
              CMD_RD_DATA: mem_re = 1'b1;
              default: ;
            endcase
          end
        end
        SHIFT_OUT: begin
          if (ocnt_q != OC_LAST) begin
            miso_d = osh_q[DATA_WIDTH-1];
            osh_d  = osh_q << 1;
            ocnt_d = ocnt_q + 1'b1;
            // Prefetch the next burst word as bit 0 goes out.
            if (BURST && (ocnt_q + 1'b1) == OC_LAST) mem_re = 1'b1;
          end
        end
        default: ;
      endcase
      if (load) begin
        miso_d   = mem_dout[DATA_WIDTH-1];
        osh_d    = mem_dout << 1;
        ocnt_d   = OC_ONE;
        rd_ptr_d = ptr_inc(rd_ptr_q);
        if (BURST && OC_ONE == OC_LAST) mem_re = 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q    <= '0;
      ish_q    <= '0;
      icnt_q   <= '0;
      osh_q    <= '0;
      ocnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      miso_q   <= 1'b0;
    end else begin
      cmd_q    <= cmd_d;
      ish_q    <= ish_d;
      icnt_q   <= icnt_d;
      osh_q    <= osh_d;
      ocnt_q   <= ocnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      miso_q   <= miso_d;
    end
  end

endmodule
